// File: rtl/cdb_rr_arbiter.sv
// Round-robin CDB arbiter: N_CH execution-unit channels plus one max-priority channel towards the ROB.
// Optional max-priority starvation guard: define CDB_ARB_STARVE_GUARD_EN.
module cdb_rr_arbiter #(
    parameter int N_CH           = 7,
    parameter int MAX_PRIO_BURST = 8,
    localparam int IDX_W         = $clog2(N_CH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             max_prio_valid_i,
    output logic             max_prio_ready_o,
    input  logic [N_CH-1:0]  valid_i,
    output logic [N_CH-1:0]  ready_o,
    input  logic             rob_ready_i,
    output logic             rob_valid_o,
    output logic             served_max_prio_o,
    output logic [IDX_W-1:0] served_o
);

    if (N_CH < 2 || MAX_PRIO_BURST < 1) begin : g_param_check
        $error("cdb_rr_arbiter: N_CH must be >= 2 and MAX_PRIO_BURST >= 1");
    end

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

    logic             any_valid;
    logic             lock_live;
    logic             scan_found;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] ord_idx;
    logic             guard_block;
    logic             mp_win;
    logic             ord_win;

`ifdef CDB_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(MAX_PRIO_BURST + 1);

    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    assign guard_block = (burst_cnt_q == CNT_W'(MAX_PRIO_BURST)) && any_valid;
`else
    assign guard_block = 1'b0;
`endif

    always_comb begin
        any_valid = |valid_i;

        // A locked channel that dropped valid no longer holds the grant this cycle.
        lock_live = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (lock_idx_q == IDX_W'(i)) begin
                lock_live = lock_q & valid_i[i];
            end
        end

        // Rotating scan: first pass covers ptr_q..N_CH-1, second pass wraps from 0.
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!scan_found && valid_i[i] && (IDX_W'(i) >= ptr_q)) begin
                scan_found = 1'b1;
                scan_idx   = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!scan_found && valid_i[i]) begin
                scan_found = 1'b1;
                scan_idx   = IDX_W'(i);
            end
        end

        ord_idx = lock_live ? lock_idx_q : scan_idx;
        mp_win  = max_prio_valid_i & ~guard_block;
        ord_win = ~mp_win & any_valid;

        rob_valid_o       = max_prio_valid_i | any_valid;
        served_max_prio_o = mp_win;
        max_prio_ready_o  = mp_win & rob_ready_i;
        served_o          = ord_win ? ord_idx + IDX_W'(1) : '0;

        ready_o = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ord_win && (ord_idx == IDX_W'(i))) begin
                ready_o[i] = rob_ready_i;
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;

        if (lock_q && !lock_live) begin
            lock_d = 1'b0;
        end

        // Max-priority preemption leaves both pointer and lock untouched.
        if (ord_win) begin
            if (rob_ready_i) begin
                lock_d = 1'b0;
                ptr_d  = (ord_idx == IDX_W'(N_CH - 1)) ? '0 : ord_idx + IDX_W'(1);
            end else begin
                lock_d     = 1'b1;
                lock_idx_d = ord_idx;
            end
        end

        if (flush_i) begin
            ptr_d      = '0;
            lock_d     = 1'b0;
            lock_idx_d = '0;
        end
    end

`ifdef CDB_ARB_STARVE_GUARD_EN
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (!any_valid || (ord_win && rob_ready_i)) begin
            burst_cnt_d = '0;
        end else if (mp_win && rob_ready_i && (burst_cnt_q != CNT_W'(MAX_PRIO_BURST))) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
        if (flush_i) begin
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed self-checking bench for cdb_rr_arbiter (N_CH=4, MAX_PRIO_BURST=3).
// Guard expectations follow CDB_ARB_STARVE_GUARD_EN as defined for the build.
module tb_cdb_rr_arbiter;

    localparam int N_CH  = 4;
    localparam int MPB   = 3;
    localparam int IDX_W = $clog2(N_CH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             mp_valid;
    logic             mp_ready;
    logic [N_CH-1:0]  valid;
    logic [N_CH-1:0]  ready;
    logic             rob_ready;
    logic             rob_valid;
    logic             served_mp;
    logic [IDX_W-1:0] served;

    int n_tests = 0;
    int n_fail  = 0;

    cdb_rr_arbiter #(
        .N_CH           (N_CH),
        .MAX_PRIO_BURST (MPB)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_i           (flush),
        .max_prio_valid_i  (mp_valid),
        .max_prio_ready_o  (mp_ready),
        .valid_i           (valid),
        .ready_o           (ready),
        .rob_ready_i       (rob_ready),
        .rob_valid_o       (rob_valid),
        .served_max_prio_o (served_mp),
        .served_o          (served)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic mp, input logic [N_CH-1:0] v, input logic rr);
        mp_valid  = mp;
        valid     = v;
        rob_ready = rr;
    endtask

    task automatic expect_out(input string tag, input int e_served, input logic [N_CH-1:0] e_ready,
                              input logic e_mp_ready, input logic e_served_mp, input logic e_rob_valid);
        #1;
        check({tag, ".served"},    32'(served),    32'(e_served));
        check({tag, ".ready"},     32'(ready),     32'(e_ready));
        check({tag, ".mp_ready"},  32'(mp_ready),  32'(e_mp_ready));
        check({tag, ".served_mp"}, 32'(served_mp), 32'(e_served_mp));
        check({tag, ".rob_valid"}, 32'(rob_valid), 32'(e_rob_valid));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] grd_ord;
`ifdef CDB_ARB_STARVE_GUARD_EN
        grd_ord = 5'b01000;
`else
        grd_ord = 5'b00000;
`endif
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b0, 4'b0000, 1'b1);
        tick();
        tick();
        rst = 1'b0;

        expect_out("reset_idle", 0, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Fairness: full request set rotates 1,2,3,4,1,...
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 4'b1111, 1'b1);
            expect_out($sformatf("fair%0d", k), (k % 4) + 1, 4'(1 << (k % 4)), 1'b0, 1'b0, 1'b1);
            tick();
        end

        // Preemption: max-priority wins, pointer (0) is unchanged
        drive(1'b1, 4'b0100, 1'b1);
        expect_out("preempt", 0, 4'b0000, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 4'b1111, 1'b1);
        expect_out("preempt_ptr_kept", 1, 4'b0001, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'b0100, 1'b1);
        expect_out("after_preempt", 3, 4'b0100, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'b1111, 1'b1);
        expect_out("ptr_after_ch2", 4, 4'b1000, 1'b0, 1'b0, 1'b1);
        tick();

        // Lock: ptr=0, channel 0 stalls
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'b0011, 1'b0);
            expect_out($sformatf("stall%0d", k), 1, 4'b0000, 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 4'b1011, 1'b0);
        expect_out("stall_add3", 1, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 4'b1011, 1'b1);
        expect_out("lock_preempt", 0, 4'b0000, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 4'b1011, 1'b1);
        expect_out("lock_release", 1, 4'b0001, 1'b0, 1'b0, 1'b1);
        tick();
        // ptr=1: lock on channel 3 must beat scan preference for channel 2
        drive(1'b0, 4'b1001, 1'b0);
        expect_out("lock3_set", 4, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'b1101, 1'b0);
        expect_out("lock3_hold", 4, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        // Locked channel drops valid: scan from ptr=1 picks channel 2 this cycle
        drive(1'b0, 4'b0101, 1'b0);
        expect_out("lock_drop", 3, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'b0101, 1'b1);
        expect_out("lock2_xfer", 3, 4'b0100, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'b0001, 1'b1);
        expect_out("wrap_scan", 1, 4'b0001, 1'b0, 1'b0, 1'b1);
        tick();

        // Flush: build ptr=2 and a lock on channel 3, then flush
        drive(1'b0, 4'b0010, 1'b1);
        expect_out("pre_flush_a", 2, 4'b0010, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'b1000, 1'b0);
        expect_out("pre_flush_b", 4, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        flush = 1'b1;
        expect_out("flush_cycle", 4, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, 4'b1111, 1'b1);
        expect_out("post_flush", 1, 4'b0001, 1'b0, 1'b0, 1'b1);
        tick();

        // Reset mid-stall: ptr=1, lock channel 2
        drive(1'b0, 4'b0100, 1'b0);
        expect_out("pre_rst_lock", 3, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'b0110, 1'b0);
        expect_out("pre_rst_hold", 3, 4'b0000, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 4'b0110, 1'b1);
        expect_out("post_rst", 2, 4'b0010, 1'b0, 1'b0, 1'b1);
        tick();

        // Starvation guard burst with channel 1 waiting
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 4'b0010, 1'b1);
            if (grd_ord[k]) begin
                expect_out($sformatf("guard%0d", k), 2, 4'b0010, 1'b0, 1'b0, 1'b1);
            end else begin
                expect_out($sformatf("guard%0d", k), 0, 4'b0000, 1'b1, 1'b1, 1'b1);
            end
            tick();
        end

        drive(1'b0, 4'b0000, 1'b1);
        expect_out("idle", 0, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'b0000, 1'b0);
        expect_out("mp_stall", 0, 4'b0000, 1'b0, 1'b1, 1'b1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
